// File: rtl/temp_regulator_if.sv
// temp_regulator_if: control inputs and actuator/status outputs of the regulator
interface temp_regulator_if;
  logic       on_off;
  logic [8:0] set_temp;
  logic [8:0] cur_temp;
  logic       heat;
  logic       cool;
  logic [1:0] state;
  logic       at_target;
  modport master(output on_off, set_temp, cur_temp, input heat, cool, state, at_target);
  modport slave(input on_off, set_temp, cur_temp, output heat, cool, state, at_target);
endinterface

// File: rtl/temp_regulator.sv
// temp_regulator: tick-paced hysteresis thermostat with minimum actuator run time
module temp_regulator #(
  parameter int TICK_DIV = 100000000,
  parameter int HYST     = 5,
  parameter int MIN_RUN  = 3
) (
  input logic             clk,
  input logic             rst,
  temp_regulator_if.slave bus
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(MIN_RUN + 1);
  typedef enum logic [1:0] {OFF = 2'd0, IDLE = 2'd1, HEAT = 2'd2, COOL = 2'd3} st_e;
  st_e st, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] run, run_nxt;
  logic [9:0] cur, set, hyst;
  logic tick, band, run_done, at_nxt;
  // widen to 10 bits so setpoint/measurement plus band never wraps
  assign cur = {1'b0, bus.cur_temp};
  assign set = {1'b0, bus.set_temp};
  assign hyst = 10'(HYST);
  assign tick = cnt == CW'(TICK_DIV - 1);
  assign band = (cur + hyst >= set) && (cur <= set + hyst);
  assign run_done = run >= RW'(MIN_RUN - 1);
  assign bus.state = st;
  always_comb begin
    nxt = st;
    run_nxt = '0;
    at_nxt = bus.at_target;
    nxt = !bus.on_off ? OFF :
          st == OFF   ? IDLE :
          !tick       ? st :
          st == IDLE  ? (cur + hyst < set ? HEAT : cur > set + hyst ? COOL : IDLE) :
          st == HEAT  ? (cur >= set && run_done ? IDLE : HEAT) :
                        (cur <= set && run_done ? IDLE : COOL);
    run_nxt = (nxt == st && (st == HEAT || st == COOL)) ?
              (tick && run != RW'(MIN_RUN) ? run + 1'b1 : run) : '0;
    at_nxt = tick ? (nxt == IDLE && band) : (nxt != st && nxt != IDLE) ? 1'b0 : bus.at_target;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      st <= OFF;
      run <= '0;
      bus.heat <= 1'b0;
      bus.cool <= 1'b0;
      bus.at_target <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      st <= nxt;
      run <= run_nxt;
      bus.heat <= nxt == HEAT;
      bus.cool <= nxt == COOL;
      bus.at_target <= at_nxt;
    end
  end
endmodule

// File: doc/temp_regulator.md
TEMP_REGULATOR -- requirements
Module: temp_regulator

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clock cycles per control tick (>=2).
REQ-002 Parameter HYST, default 5, hysteresis band in 0.1 degC units.
REQ-003 Parameter MIN_RUN, default 3, minimum ticks an actuator stays on once started.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 on_off  input  1  system enable; 1 means the regulator is active.
REQ-007 set_temp  input  9  setpoint, unsigned, 0.1 degC units, nominal range 200..300 in steps of 10.
REQ-008 cur_temp  input  9  measured temperature, unsigned, 0.1 degC units, full range 0..511 legal.
REQ-009 heat  output  1  heater drive, registered.
REQ-010 cool  output  1  cooler drive, registered.
REQ-011 state  output  2  FSM state: OFF=0, IDLE=1, HEAT=2, COOL=3.
REQ-012 at_target  output  1  registered flag; regulator is idle and within band.

Function
REQ-013 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is high for the one cycle where count = TICK_DIV-1; the counter runs regardless of on_off.
REQ-014 on_off=0 SHALL force state OFF on the next edge from any state, without waiting for a tick, with heat=cool=0 and run counter cleared.
REQ-015 OFF with on_off=1 SHALL move to IDLE on the next edge.
REQ-016 IDLE, on tick: cur_temp + HYST < set_temp -> HEAT; cur_temp > set_temp + HYST -> COOL; otherwise stay IDLE.
REQ-017 All comparisons SHALL use 10-bit unsigned arithmetic so that no sum wraps.
REQ-018 On entry to HEAT or COOL, run counter SHALL be 0; it SHALL increment on each tick while in HEAT/COOL, saturating at MIN_RUN.
REQ-019 HEAT, on tick: if cur_temp >= set_temp and run counter (pre-increment) >= MIN_RUN-1 -> IDLE; else stay HEAT.
REQ-020 COOL, on tick: if cur_temp <= set_temp and run counter (pre-increment) >= MIN_RUN-1 -> IDLE; else stay COOL.
REQ-021 HEAT SHALL NOT transition directly to COOL, nor COOL directly to HEAT; the path is always via IDLE.
REQ-022 heat SHALL be 1 exactly when state=HEAT; cool SHALL be 1 exactly when state=COOL; heat and cool SHALL never both be 1.
REQ-023 at_target SHALL update on tick to 1 iff the next state is IDLE and |cur_temp - set_temp| <= HYST; it SHALL clear on the edge state enters OFF, HEAT or COOL.
REQ-024 Changes to set_temp or cur_temp between ticks SHALL have no effect until the next tick, except via REQ-014.
REQ-025 If tick and on_off=0 coincide, OFF SHALL take priority.

Reset
REQ-026 rst=0 SHALL immediately and asynchronously set state=OFF, heat=0, cool=0, at_target=0, tick counter=0, run counter=0.
REQ-027 Reset asserted mid-HEAT or mid-COOL SHALL drop the actuator output without waiting for a clock or MIN_RUN.
REQ-028 After rst release, behaviour SHALL resume per REQ-015, with the first tick TICK_DIV cycles after release.

Verification (TICK_DIV=4, HYST=5, MIN_RUN=2)
REQ-029 Reset: rst=0 with any inputs -> state=0, heat=cool=at_target=0 with no clock edge.
REQ-030 Heat start: on_off=1, set=250, cur=240 after release -> state=1 after edge 1; state=2 and heat=1 after the first tick.
REQ-031 Minimum run: in HEAT, cur raised to 250 before the first tick in HEAT -> stays HEAT at that tick (run 0 -> 1); goes to IDLE with heat=0 and at_target=1 at the next tick.
REQ-032 Band edges: set=200, cur=205 -> IDLE persists with at_target=1; cur=206 -> COOL and cool=1 at the next tick; set=250, cur=245 -> IDLE; cur=244 -> HEAT.
REQ-033 Disable: on_off dropped mid-COOL between ticks -> state=0 and cool=0 on the next edge; on_off=1 again -> IDLE on the following edge.
REQ-034 Async reset mid-HEAT: rst pulsed low between edges -> heat=0 and state=0 immediately; no actuator output after release until a tick satisfies REQ-016.
